// File: rtl/fact_engine.sv
// fact_engine: memory-mapped factorial accelerator.
// Reads N from mem[base], computes N! with a serial shift-add multiplier,
// writes the truncated result to mem[base-2] and flags any overflow.
module fact_engine #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk1,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [DATA_W-1:0] result,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  localparam int unsigned BW = $clog2(DATA_W);

  typedef enum logic [2:0] {IDLE, RD, MUL, DEC, WR, DONE} state_t;

  state_t              state;
  logic [ADDR_W-1:0]   base;
  logic [DATA_W-1:0]   acc;
  logic [DATA_W-1:0]   cnt;
  logic [2*DATA_W-1:0] prod;
  logic [BW-1:0]       bitcnt;

  logic [DATA_W:0]     psum;
  logic [2*DATA_W-1:0] prod_step;
  logic [DATA_W-1:0]   cnt_dec;
  logic                last_bit;

  // One multiplier step: add acc into the high half when the current LSB is set, then shift.
  // The multiplier (cnt) starts in the low half and is consumed as the product grows in.
  always_comb begin
    psum      = {1'b0, prod[2*DATA_W-1:DATA_W]} + (prod[0] ? {1'b0, acc} : '0);
    prod_step = {psum, prod[DATA_W-1:1]};
    cnt_dec   = cnt - DATA_W'(1);
    last_bit  = (bitcnt == BW'(DATA_W - 1));
  end

  // Only IDLE is non-busy.
  assign busy = (state != IDLE);

  // Control FSM with registered memory-port and status outputs.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      base      <= '0;
      acc       <= '0;
      cnt       <= '0;
      prod      <= '0;
      bitcnt    <= '0;
      done      <= 1'b0;
      overflow  <= 1'b0;
      result    <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            base     <= base_addr;
            overflow <= 1'b0;
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= base_addr;
            state    <= RD;
          end
        end
        RD: begin
          if (mem_ack) begin
            cnt <= mem_rdata;
            acc <= DATA_W'(1);
            if (mem_rdata <= DATA_W'(1)) begin
              // 0! = 1! = 1: go straight to the write, request stays up with new fields
              mem_we    <= 1'b1;
              mem_addr  <= base - ADDR_W'(2);
              mem_wdata <= DATA_W'(1);
              state     <= WR;
            end else begin
              mem_req <= 1'b0;
              prod    <= {{DATA_W{1'b0}}, mem_rdata};
              bitcnt  <= '0;
              state   <= MUL;
            end
          end
        end
        MUL: begin
          prod   <= prod_step;
          bitcnt <= bitcnt + BW'(1);
          if (last_bit) begin
            acc      <= prod_step[DATA_W-1:0];
            overflow <= overflow | (|prod_step[2*DATA_W-1:DATA_W]);
            state    <= DEC;
          end
        end
        DEC: begin
          cnt <= cnt_dec;
          if (cnt_dec == DATA_W'(1)) begin
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= base - ADDR_W'(2);
            mem_wdata <= acc;
            state     <= WR;
          end else begin
            prod   <= {{DATA_W{1'b0}}, cnt_dec};
            bitcnt <= '0;
            state  <= MUL;
          end
        end
        WR: begin
          if (mem_ack) begin
            result  <= acc;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            done    <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fact_engine.sv
// Testbench for fact_engine: a 32-bit and an 8-bit instance, each with a small
// memory responder whose ack delay is programmable.
module tb_fact_engine;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // 32-bit instance
  logic        start32;
  logic [9:0]  base32;
  logic        busy32, done32, ovf32, req32, we32, ack32;
  logic [31:0] res32, wd32, rd32;
  logic [9:0]  addr32;

  // 8-bit instance
  logic        start8;
  logic [9:0]  base8;
  logic        busy8, done8, ovf8, req8, we8, ack8;
  logic [7:0]  res8, wd8, rd8;
  logic [9:0]  addr8;

  fact_engine #(.DATA_W(32), .ADDR_W(10)) dut32 (
    .clk1(clk), .rst_n(rst_n), .start(start32), .base_addr(base32),
    .busy(busy32), .done(done32), .overflow(ovf32), .result(res32),
    .mem_req(req32), .mem_we(we32), .mem_addr(addr32), .mem_wdata(wd32),
    .mem_rdata(rd32), .mem_ack(ack32)
  );

  fact_engine #(.DATA_W(8), .ADDR_W(10)) dut8 (
    .clk1(clk), .rst_n(rst_n), .start(start8), .base_addr(base8),
    .busy(busy8), .done(done8), .overflow(ovf8), .result(res8),
    .mem_req(req8), .mem_we(we8), .mem_addr(addr8), .mem_wdata(wd8),
    .mem_rdata(rd8), .mem_ack(ack8)
  );

  int dly = 0;

  logic [31:0] mem32 [0:1023];
  logic [7:0]  mem8  [0:1023];

  // Responder logs (one set per instance)
  int nwr32 = 0, nrd32 = 0, unst32 = 0, wc32 = 0;
  int waddr32 = 0, raddr32 = 0;
  logic [31:0] wlog32 = '0;
  logic [9:0]  cap_a32;
  logic        cap_we32;
  logic [31:0] cap_wd32;

  int nwr8 = 0, nrd8 = 0, unst8 = 0, wc8 = 0;
  int waddr8 = 0, raddr8 = 0;
  logic [7:0]  wlog8 = '0;
  logic [9:0]  cap_a8;
  logic        cap_we8;
  logic [7:0]  cap_wd8;

  always @(negedge clk) begin
    if (req32) begin
      if (wc32 == 0) begin
        cap_a32 = addr32; cap_we32 = we32; cap_wd32 = wd32;
      end else if (addr32 != cap_a32 || we32 != cap_we32 || wd32 != cap_wd32) begin
        unst32++;
      end
      if (wc32 == dly) begin
        ack32 = 1'b1;
        wc32  = 0;
        if (we32) begin nwr32++; waddr32 = int'(addr32); wlog32 = wd32; end
        else begin nrd32++; raddr32 = int'(addr32); rd32 = mem32[addr32]; end
      end else begin
        ack32 = 1'b0;
        wc32++;
      end
    end else begin
      ack32 = 1'b0;
      wc32  = 0;
    end
  end

  always @(negedge clk) begin
    if (req8) begin
      if (wc8 == 0) begin
        cap_a8 = addr8; cap_we8 = we8; cap_wd8 = wd8;
      end else if (addr8 != cap_a8 || we8 != cap_we8 || wd8 != cap_wd8) begin
        unst8++;
      end
      if (wc8 == dly) begin
        ack8 = 1'b1;
        wc8  = 0;
        if (we8) begin nwr8++; waddr8 = int'(addr8); wlog8 = wd8; end
        else begin nrd8++; raddr8 = int'(addr8); rd8 = mem8[addr8]; end
      end else begin
        ack8 = 1'b0;
        wc8++;
      end
    end else begin
      ack8 = 1'b0;
      wc8  = 0;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Start a run and return latency in edges from the start-sampling edge (-1 on timeout)
  task automatic run(input int sel, input int n, input int base, output int lat);
    int t0;
    @(negedge clk);
    if (sel == 0) begin mem32[base] = 32'(n); base32 = 10'(base); start32 = 1'b1; end
    else begin mem8[base] = 8'(n); base8 = 10'(base); start8 = 1'b1; end
    @(negedge clk);
    start32 = 1'b0;
    start8  = 1'b0;
    t0  = cyc;
    lat = -1;
    for (int i = 0; i < 2000; i++) begin
      if ((sel == 0) ? done32 : done8) begin
        lat = cyc - t0;
        break;
      end
      @(negedge clk);
    end
  endtask

  typedef struct {
    int          sel;   // 0: 32-bit instance, 1: 8-bit instance
    int          n;
    int          base;
    int          d;
    logic [31:0] res;
    bit          ovf;
    int          waddr;
    int          lat;
  } vec_t;

  vec_t vecs [11];

  initial begin
    int lat, wr0, rd0, un0, ndone, wr_before;

    // Latency: 2 + (N-1)*(DATA_W+1) for N>=2, 2 for N<=1, plus 2*delay
    vecs[0]  = '{0, 7,  200, 0, 32'd5040,       1'b0, 198,  200};
    vecs[1]  = '{0, 0,  200, 0, 32'd1,          1'b0, 198,  2};
    vecs[2]  = '{0, 1,  200, 0, 32'd1,          1'b0, 198,  2};
    vecs[3]  = '{0, 12, 200, 0, 32'd479001600,  1'b0, 198,  365};
    vecs[4]  = '{0, 13, 200, 0, 32'd1932053504, 1'b1, 198,  398};
    vecs[5]  = '{0, 5,  200, 0, 32'd120,        1'b0, 198,  134};
    vecs[6]  = '{1, 5,  200, 0, 32'd120,        1'b0, 198,  38};
    vecs[7]  = '{1, 6,  200, 0, 32'd208,        1'b1, 198,  47};
    vecs[8]  = '{0, 5,  1,   3, 32'd120,        1'b0, 1023, 140};
    vecs[9]  = '{0, 3,  0,   0, 32'd6,          1'b0, 1022, 68};
    vecs[10] = '{1, 1,  200, 3, 32'd1,          1'b0, 198,  8};

    rst_n = 1'b0; start32 = 1'b0; start8 = 1'b0; base32 = '0; base8 = '0;
    ack32 = 1'b0; ack8 = 1'b0; rd32 = '0; rd8 = '0;
    repeat (3) @(negedge clk);

    chk("rst_busy",  busy32, 0);
    chk("rst_done",  done32, 0);
    chk("rst_ovf",   ovf32,  0);
    chk("rst_req",   req32,  0);
    chk("rst_we",    we32,   0);
    chk("rst_res",   res32,  0);
    chk("rst_addr",  addr32, 0);
    chk("rst_wdata", wd32,   0);
    chk("rst_busy8", busy8,  0);
    rst_n = 1'b1;

    for (int v = 0; v < 11; v++) begin
      dly = vecs[v].d;
      wr0 = (vecs[v].sel == 0) ? nwr32 : nwr8;
      rd0 = (vecs[v].sel == 0) ? nrd32 : nrd8;
      un0 = (vecs[v].sel == 0) ? unst32 : unst8;
      run(vecs[v].sel, vecs[v].n, vecs[v].base, lat);
      chk($sformatf("v%0d_latency", v), lat, vecs[v].lat);
      @(negedge clk);
      if (vecs[v].sel == 0) begin
        chk($sformatf("v%0d_result", v), res32, vecs[v].res);
        chk($sformatf("v%0d_ovf", v), ovf32, vecs[v].ovf);
        chk($sformatf("v%0d_nwrites", v), nwr32 - wr0, 1);
        chk($sformatf("v%0d_nreads", v), nrd32 - rd0, 1);
        chk($sformatf("v%0d_raddr", v), raddr32, vecs[v].base);
        chk($sformatf("v%0d_waddr", v), waddr32, vecs[v].waddr);
        chk($sformatf("v%0d_wdata", v), wlog32, vecs[v].res);
        chk($sformatf("v%0d_stable", v), unst32 - un0, 0);
        chk($sformatf("v%0d_busy_after", v), busy32, 0);
      end else begin
        chk($sformatf("v%0d_result", v), res8, vecs[v].res);
        chk($sformatf("v%0d_ovf", v), ovf8, vecs[v].ovf);
        chk($sformatf("v%0d_nwrites", v), nwr8 - wr0, 1);
        chk($sformatf("v%0d_nreads", v), nrd8 - rd0, 1);
        chk($sformatf("v%0d_raddr", v), raddr8, vecs[v].base);
        chk($sformatf("v%0d_waddr", v), waddr8, vecs[v].waddr);
        chk($sformatf("v%0d_wdata", v), wlog8, vecs[v].res);
        chk($sformatf("v%0d_stable", v), unst8 - un0, 0);
        chk($sformatf("v%0d_busy_after", v), busy8, 0);
      end
    end

    // Reset in the middle of a multiply aborts the run with no write and no done
    dly = 0;
    mem32[200] = 32'd7;
    @(negedge clk);
    base32 = 10'd200; start32 = 1'b1;
    @(negedge clk);
    start32 = 1'b0;
    repeat (40) @(negedge clk);
    chk("mid_busy", busy32, 1);
    wr_before = nwr32;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", busy32, 0);
    chk("abort_req",  req32,  0);
    chk("abort_res",  res32,  0);
    chk("abort_done", done32, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (done32) ndone++;
    end
    chk("abort_nodone",  ndone, 0);
    chk("abort_nowrite", nwr32 - wr_before, 0);

    run(0, 7, 200, lat);
    chk("fresh_latency", lat, 200);
    @(negedge clk);
    chk("fresh_result", res32, 5040);
    chk("fresh_waddr",  waddr32, 198);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fact_engine.md
# fact_engine

Parametrised hardware factorial engine: the successor to the MUL/SUBI/BNEQZ factorial loop that the MIPS32 core runs in software. On a start pulse it reads N from data memory at a base address, computes N! with an iterative shift-add multiplier, and writes the result back to base−2. It sits beside the pipeline on the data-memory port as a memory-mapped accelerator, with a single-request memory handshake and a sticky overflow flag. Datapath width and address width are generic.

## Interface
- DATA_W, 32, operand/result width; must be ≥ 4
- ADDR_W, 10, memory word-address width
- clk1  in  1  single clock; all state updates on the rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request; sampled only in IDLE
- base_addr  in  ADDR_W  address of N; latched when start is accepted
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when the result write has completed
- overflow  out  1  N! exceeded DATA_W bits during the current run
- result  out  DATA_W  last computed value, truncated to DATA_W
- mem_req  out  1  memory request
- mem_we  out  1  1 = write, 0 = read; valid while mem_req is high
- mem_addr  out  ADDR_W  request address
- mem_wdata  out  DATA_W  write data
- mem_rdata  in  DATA_W  read data; valid in the cycle mem_ack is high
- mem_ack  in  1  request completion; sampled on the clock edge

## Operation
- States: IDLE, RD, MUL, DEC, WR, DONE.
- IDLE: when start=1, latch base_addr, clear overflow, and go to RD. start is ignored in every other state.
- RD: mem_req=1, mem_we=0, mem_addr=base. On mem_ack, capture N into cnt and set acc=1.
  - If N≤1, go to WR.
  - Otherwise go to MUL.
- MUL: shift-add multiply of acc × cnt, one multiplier bit per cycle, LSB first. Uses a 2·DATA_W product register. Stays in MUL for exactly DATA_W cycles.
- Leaving MUL:
  - acc ← low DATA_W bits of the product.
  - overflow ← overflow | (high half ≠ 0).
- DEC: cnt ← cnt−1. If the new cnt=1, go to WR; otherwise go back to MUL. There is never a multiply by 1.
- WR:
  - mem_req=1, mem_we=1.
  - mem_addr = base−2, modulo 2^ADDR_W, so base 0 maps to 2^ADDR_W−2 and base 1 maps to 2^ADDR_W−1.
  - mem_wdata = acc. On mem_ack, result ← acc and go to DONE.
- DONE: done=1 for one cycle, then go to IDLE.
- N is treated as unsigned.
- overflow and result hold their values until the next accepted start; that start clears overflow only.

## Timing
- Reset values (asynchronous, immediate): state=IDLE; busy, done, overflow, mem_req and mem_we are 0; result, mem_addr, mem_wdata, acc and cnt are 0.
- Handshake:
  - mem_req rises the cycle after entry to RD or WR.
  - mem_addr, mem_we and mem_wdata are stable while mem_req is high.
  - mem_req drops in the cycle after the edge that samples mem_ack=1.
  - mem_ack while mem_req=0 is ignored.
- Latency, with zero-wait ack and start sampled at edge 0:
  - done is high in the cycle after edge 2+(N−1)(DATA_W+1) for N≥2.
  - done is high in the cycle after edge 2 for N≤1.
- Each wait cycle on mem_ack adds one cycle.
- Reset asserted mid-operation aborts immediately: no write is issued and done does not pulse.
- start coincident with done is ignored, because the block is not in IDLE.

## Test plan
- DATA_W=32, Mem[200]=7, start with base_addr=200, immediate ack → one read at 200; one write of 5040 to 198; overflow=0; done in the cycle after edge 200.
- Mem[200]=0, then a separate run with Mem[200]=1 → each writes 1 to 198; no MUL state is entered; done in the cycle after edge 2.
- Mem[200]=12 → 479001600 with overflow=0. Mem[200]=13 → 1932053504 with overflow=1. A following run with N=5 clears overflow and gives 120.
- DATA_W=8, N=5 → 120 with overflow=0. N=6 → 208 with overflow=1.
- mem_ack delayed by 3 cycles on both read and write → request fields stay stable and latency grows by 6. With base_addr=1 and ADDR_W=10 the write goes to 1023.
- rst_n pulsed low during MUL for N=7 → outputs return to reset values immediately, no write occurs, and a fresh start completes normally.
